// File: rtl/reg_file_pkg.sv
// Shared widths, types and constants for the architectural register file.
// Optional feature macro: REG_FILE_COMMIT_BYPASS_EN (same-cycle commit bypass on reads).
package reg_file_pkg;

  localparam int XLEN      = 32;
  localparam int REG_ID_W  = 5;
  localparam int ROB_ID_W  = 4;
  localparam int REG_COUNT = 1 << REG_ID_W;

  typedef logic [XLEN-1:0]     reg_t;
  typedef logic [REG_ID_W-1:0] reg_id_t;
  typedef logic [ROB_ID_W-1:0] rob_id_t;

  // ROB id 0 marks "no pending producer".
  localparam rob_id_t ROB_NONE = '0;

endpackage

// File: rtl/reg_file_read_port.sv
// Combinational register lookup returning producer tag and committed value.
// With REG_FILE_COMMIT_BYPASS_EN, a same-cycle commit of the pending producer is forwarded.
module reg_file_read_port
  import reg_file_pkg::*;
(
  input  reg_id_t rs,
  input  reg_t    values [1:REG_COUNT-1],
  input  rob_id_t tags   [1:REG_COUNT-1],
  input  rob_id_t commit_dest,
  input  reg_t    commit_value,
  output rob_id_t q,
  output reg_t    v
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    q = ROB_NONE;
    v = '0;
    if (rs != '0) begin
      q = tags[rs];
      v = values[rs];
`ifdef REG_FILE_COMMIT_BYPASS_EN
      if (commit_dest != ROB_NONE && tags[rs] == commit_dest) begin
        q = ROB_NONE;
        v = commit_value;
      end
`endif
    end
  end

`ifndef REG_FILE_COMMIT_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{commit_dest, commit_value};
`endif

endmodule

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags, fed by ROB commits and issuer renames.
// Optional feature macro: REG_FILE_COMMIT_BYPASS_EN (see reg_file_read_port).
module reg_file
  import reg_file_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    rdy,
  input  reg_id_t rs1_from_issuer,
  input  reg_id_t rs2_from_issuer,
  output rob_id_t qj_to_issuer,
  output reg_t    vj_to_issuer,
  output rob_id_t qk_to_issuer,
  output reg_t    vk_to_issuer,
  input  logic    valid_from_issuer,
  input  reg_id_t rd_from_issuer,
  input  rob_id_t dest_from_issuer,
  input  rob_id_t dest_from_rob,
  input  reg_id_t rd_from_rob,
  input  reg_t    value_from_rob,
  input  logic    reset_from_rob_bus
);

  reg_t    values [1:REG_COUNT-1];
  rob_id_t tags   [1:REG_COUNT-1];

  logic commit;
  logic rename;

  assign commit = (dest_from_rob != ROB_NONE) && (rd_from_rob != '0);
  assign rename = valid_from_issuer && (rd_from_issuer != '0);

  // NOTE: the storage array is reset explicitly because reads must return 0/0 right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        // NOTE: state updates use non-blocking assignments so later statements see pre-edge values.
        values[i] <= '0;
        tags[i]   <= ROB_NONE;
      end
    end else if (rdy) begin
      if (commit) begin
        values[rd_from_rob] <= value_from_rob;
        if (tags[rd_from_rob] == dest_from_rob)
          tags[rd_from_rob] <= ROB_NONE;
      end
      // Later assignments win: a flush clears every tag, otherwise a rename overrides the commit clear.
      if (reset_from_rob_bus) begin
        for (int i = 1; i < REG_COUNT; i++)
          tags[i] <= ROB_NONE;
      end else if (rename) begin
        tags[rd_from_issuer] <= dest_from_issuer;
      end
    end
  end

  reg_file_read_port u_read_rs1 (
    .rs           (rs1_from_issuer),
    .values       (values),
    .tags         (tags),
    .commit_dest  (dest_from_rob),
    .commit_value (value_from_rob),
    .q            (qj_to_issuer),
    .v            (vj_to_issuer)
  );

  reg_file_read_port u_read_rs2 (
    .rs           (rs2_from_issuer),
    .values       (values),
    .tags         (tags),
    .commit_dest  (dest_from_rob),
    .commit_value (value_from_rob),
    .q            (qk_to_issuer),
    .v            (vk_to_issuer)
  );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expected reads, a monitor pops and compares.
// Honours REG_FILE_COMMIT_BYPASS_EN in the reference model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic [4:0]  rs1_from_issuer = '0, rs2_from_issuer = '0;
  logic [3:0]  qj_to_issuer, qk_to_issuer;
  logic [31:0] vj_to_issuer, vk_to_issuer;
  logic        valid_from_issuer = 1'b0;
  logic [4:0]  rd_from_issuer = '0;
  logic [3:0]  dest_from_issuer = '0;
  logic [3:0]  dest_from_rob = '0;
  logic [4:0]  rd_from_rob = '0;
  logic [31:0] value_from_rob = '0;
  logic        reset_from_rob_bus = 1'b0;

  reg_file dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .rs1_from_issuer    (rs1_from_issuer),
    .rs2_from_issuer    (rs2_from_issuer),
    .qj_to_issuer       (qj_to_issuer),
    .vj_to_issuer       (vj_to_issuer),
    .qk_to_issuer       (qk_to_issuer),
    .vk_to_issuer       (vk_to_issuer),
    .valid_from_issuer  (valid_from_issuer),
    .rd_from_issuer     (rd_from_issuer),
    .dest_from_issuer   (dest_from_issuer),
    .dest_from_rob      (dest_from_rob),
    .rd_from_rob        (rd_from_rob),
    .value_from_rob     (value_from_rob),
    .reset_from_rob_bus (reset_from_rob_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        valid;
    logic [4:0]  rd;
    logic [3:0]  dest;
    logic [3:0]  rob_dest;
    logic [4:0]  rob_rd;
    logic [31:0] rob_val;
    logic        flush;
    logic        rdy;
  } stim_t;

  typedef struct {
    string       label;
    logic [3:0]  q1, q2;
    logic [31:0] v1, v2;
  } exp_t;

  exp_t  exp_q[$];
  event  sample_ev;
  int    checks   = 0;
  int    failures = 0;

  // Reference state: plain arrays, entry 0 never written.
  logic [3:0]  m_tag [32];
  logic [31:0] m_val [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic stim_t idle(input logic [4:0] rs1, input logic [4:0] rs2);
    stim_t s;
    s.rs1 = rs1; s.rs2 = rs2; s.valid = 1'b0; s.rd = '0; s.dest = '0;
    s.rob_dest = '0; s.rob_rd = '0; s.rob_val = '0; s.flush = 1'b0; s.rdy = 1'b1;
    return s;
  endfunction

  task automatic model_read(input logic [4:0] rs, input stim_t s,
                            output logic [3:0] q, output logic [31:0] v);
    q = (rs == 0) ? 4'd0 : m_tag[rs];
    v = (rs == 0) ? 32'd0 : m_val[rs];
`ifdef REG_FILE_COMMIT_BYPASS_EN
    if (rs != 0 && s.rob_dest != 0 && q == s.rob_dest) begin
      q = 4'd0;
      v = s.rob_val;
    end
`endif
  endtask

  task automatic push_expect(input string label, input stim_t s);
    exp_t e;
    e.label = label;
    model_read(s.rs1, s, e.q1, e.v1);
    model_read(s.rs2, s, e.q2, e.v2);
    exp_q.push_back(e);
    ->sample_ev;
  endtask

  task automatic cycle(input string label, input stim_t s);
    @(negedge clk);
    rs1_from_issuer    = s.rs1;
    rs2_from_issuer    = s.rs2;
    valid_from_issuer  = s.valid;
    rd_from_issuer     = s.rd;
    dest_from_issuer   = s.dest;
    dest_from_rob      = s.rob_dest;
    rd_from_rob        = s.rob_rd;
    value_from_rob     = s.rob_val;
    reset_from_rob_bus = s.flush;
    rdy                = s.rdy;
    #1;
    push_expect(label, s);
    @(posedge clk);
    if (s.rdy) begin
      if (s.rob_dest != 0 && s.rob_rd != 0) begin
        m_val[s.rob_rd] = s.rob_val;
        if (m_tag[s.rob_rd] == s.rob_dest) m_tag[s.rob_rd] = 4'd0;
      end
      if (s.flush) begin
        for (int i = 0; i < 32; i++) m_tag[i] = 4'd0;
      end else if (s.valid && s.rd != 0) begin
        m_tag[s.rd] = s.dest;
      end
    end
  endtask

  // Asserts rst mid-cycle and checks outputs clear immediately, without a clock edge.
  task automatic async_reset(input logic [4:0] rs1, input logic [4:0] rs2);
    stim_t s;
    s = idle(rs1, rs2);
    @(negedge clk);
    rs1_from_issuer = rs1; rs2_from_issuer = rs2;
    valid_from_issuer = 1'b0; dest_from_rob = '0; reset_from_rob_bus = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      m_tag[i] = 4'd0;
      m_val[i] = 32'd0;
    end
    push_expect("async_reset", s);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(sample_ev);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty actual=0 expected=1");
      end else begin
        e = exp_q.pop_front();
        check({e.label, ".qj"}, 32'(qj_to_issuer), 32'(e.q1));
        check({e.label, ".vj"}, vj_to_issuer, e.v1);
        check({e.label, ".qk"}, 32'(qk_to_issuer), 32'(e.q2));
        check({e.label, ".vk"}, vk_to_issuer, e.v2);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    stim_t s;
    for (int i = 0; i < 32; i++) begin
      m_tag[i] = 4'd0;
      m_val[i] = 32'd0;
    end

    async_reset(5'd5, 5'd0);

    // Rename x5 -> 3, then commit it.
    s = idle(5'd5, 5'd0); s.valid = 1'b1; s.rd = 5'd5; s.dest = 4'd3;
    cycle("x5_rename", s);
    s = idle(5'd5, 5'd0); s.rob_dest = 4'd3; s.rob_rd = 5'd5; s.rob_val = 32'hDEADBEEF;
    cycle("x5_commit", s);
    cycle("x5_after", idle(5'd5, 5'd0));

    // Older commit must not clear a younger rename.
    s = idle(5'd7, 5'd5); s.valid = 1'b1; s.rd = 5'd7; s.dest = 4'd2;
    cycle("x7_rename2", s);
    s = idle(5'd7, 5'd5); s.valid = 1'b1; s.rd = 5'd7; s.dest = 4'd6;
    cycle("x7_rename6", s);
    s = idle(5'd7, 5'd5); s.rob_dest = 4'd2; s.rob_rd = 5'd7; s.rob_val = 32'h11;
    cycle("x7_commit2", s);
    cycle("x7_after", idle(5'd7, 5'd0));

    // Writes to x0 are ignored.
    s = idle(5'd0, 5'd0); s.valid = 1'b1; s.rd = 5'd0; s.dest = 4'd4;
    s.rob_dest = 4'd4; s.rob_rd = 5'd0; s.rob_val = 32'hFF;
    cycle("x0_write", s);
    cycle("x0_after", idle(5'd0, 5'd0));

    // Flush with same-cycle commit and rename.
    s = idle(5'd1, 5'd2); s.valid = 1'b1; s.rd = 5'd1; s.dest = 4'd5;
    cycle("x1_rename", s);
    s = idle(5'd1, 5'd2); s.valid = 1'b1; s.rd = 5'd2; s.dest = 4'd7;
    cycle("x2_rename", s);
    s = idle(5'd1, 5'd2); s.flush = 1'b1; s.rob_dest = 4'd5; s.rob_rd = 5'd1; s.rob_val = 32'h42;
    s.valid = 1'b1; s.rd = 5'd3; s.dest = 4'd8;
    cycle("flush", s);
    cycle("flush_after12", idle(5'd1, 5'd2));
    cycle("flush_after3", idle(5'd3, 5'd0));

    // Same-cycle commit of the current producer: bypass visible only with the macro.
    s = idle(5'd9, 5'd0); s.valid = 1'b1; s.rd = 5'd9; s.dest = 4'd9;
    cycle("x9_rename", s);
    s = idle(5'd9, 5'd9); s.rob_dest = 4'd9; s.rob_rd = 5'd9; s.rob_val = 32'h1234;
    cycle("x9_bypass", s);

    // Stall suppresses all writes.
    s = idle(5'd4, 5'd0); s.rdy = 1'b0; s.valid = 1'b1; s.rd = 5'd4; s.dest = 4'd1;
    s.rob_dest = 4'd1; s.rob_rd = 5'd4; s.rob_val = 32'hBAD;
    cycle("stall", s);
    cycle("stall_after", idle(5'd4, 5'd0));

    // Randomized traffic on a small register window to force collisions.
    for (int n = 0; n < 2000; n++) begin
      s = idle(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      s.valid = ($urandom_range(0, 1) == 1);
      s.rd    = 5'($urandom_range(0, 7));
      s.dest  = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 9) < 6) begin
        s.rob_rd  = 5'($urandom_range(0, 7));
        s.rob_val = $urandom;
        s.rob_dest = (m_tag[s.rob_rd] != 0 && $urandom_range(0, 1) == 1)
                     ? m_tag[s.rob_rd] : 4'($urandom_range(1, 15));
      end
      s.flush = ($urandom_range(0, 19) == 0);
      s.rdy   = ($urandom_range(0, 9) != 0);
      cycle("random", s);
      if (n == 1000) async_reset(5'($urandom_range(1, 7)), 5'($urandom_range(1, 7)));
    end

    @(negedge clk);
    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
